int2float_param: RTL and testbench

//  Parametrised integer to IEEE-754 single-precision converter; next generation of our int-to-float unit.
//  - Input width and signedness are configurable.
//  - Normalisation uses a one-cycle leading-zero count, so latency is fixed.
//  - Reports an inexact flag; optional runtime rounding mode.
//  - Sits between integer datapath stages and FP units on the stb/ack stream interface used across dsa/rtl.

---
 rtl/int2float_param_if.sv | 63 ++++++
 rtl/int2float_param.sv | 181 ++++++++++++++++++
 tb/tb_int2float_param.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/int2float_param_if.sv
// ---------------------------------------------------------------------------
// int2float_param_if
// Stream interface carrying one integer operand into the int-to-float
// converter and one float32 result out of it (stb/ack handshake on both sides).
//
// Signals
//   input_a       integer operand, INT_W bits
//   input_a_stb   producer has a valid operand
//   input_a_ack   converter can take an operand
//   input_rmode   rounding mode, only present when INT2FLOAT_RMODE_EN is defined
//   output_z      float32 result
//   output_z_inx  result is inexact, qualified by output_z_stb
//   output_z_stb  result valid
//   output_z_ack  consumer takes the result
//
// Modports
//   master  producer/consumer side (drives operand and result ack)
//   slave   converter side
//
// Configuration macro: INT2FLOAT_RMODE_EN
// ---------------------------------------------------------------------------
interface int2float_param_if #(
  parameter int INT_W = 32
);

  logic [INT_W-1:0] input_a;
  logic             input_a_stb;
  logic             input_a_ack;
`ifdef INT2FLOAT_RMODE_EN
  logic [1:0]       input_rmode;
`endif
  logic [31:0]      output_z;
  logic             output_z_inx;
  logic             output_z_stb;
  logic             output_z_ack;

  modport master (
    output input_a,
    output input_a_stb,
    input  input_a_ack,
`ifdef INT2FLOAT_RMODE_EN
    output input_rmode,
`endif
    input  output_z,
    input  output_z_inx,
    input  output_z_stb,
    output output_z_ack
  );

  modport slave (
    input  input_a,
    input  input_a_stb,
    output input_a_ack,
`ifdef INT2FLOAT_RMODE_EN
    input  input_rmode,
`endif
    output output_z,
    output output_z_inx,
    output output_z_stb,
    input  output_z_ack
  );

endinterface

// File: rtl/int2float_param.sv
// ---------------------------------------------------------------------------
// int2float_param
// Converts an INT_W-bit integer (signed or unsigned) into an IEEE-754 single
// precision value with a fixed-latency pipeline of FSM states:
//   GET_A -> ABS -> NORM -> ROUND -> PACK -> PUT_Z
// Only one conversion is in flight at a time.
//
// Parameters
//   INT_W      input integer width (8..64)
//   SIGNED_IN  1: operand is two's complement, 0: operand is unsigned
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   int2float_param_if slave modport (operand in, result out)
//
// Configuration macro: INT2FLOAT_RMODE_EN
//   defined   : rounding mode is taken from input_rmode with each operand
//               (00 RNE, 01 RTZ, 10 RUP, 11 RDN)
//   undefined : round-to-nearest-even only
// ---------------------------------------------------------------------------
module int2float_param #(
  parameter int INT_W     = 32,
  parameter int SIGNED_IN = 1
) (
  input logic clk,
  input logic rst,
  int2float_param_if.slave bus
);

  localparam int LZ_W = $clog2(INT_W + 1);

  typedef enum logic [2:0] {
    GET_A,
    ABS,
    NORM,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  state_t           state;
  logic [INT_W-1:0] a_reg;
  logic [INT_W-1:0] mag;
  logic             sign;
  logic [23:0]      mant;
  logic             g;
  logic             r;
  logic             s;
  logic [7:0]       exp_q;
  logic             zero;
  logic             inx;
`ifdef INT2FLOAT_RMODE_EN
  logic [1:0]       rmode_reg;
`endif

  logic             neg;
  logic [LZ_W-1:0]  lzc;
  logic [INT_W-1:0] norm;
  logic [INT_W+25:0] wide;
  logic [24:0]      mant_inc;
  logic             round_up;

  assign neg = (SIGNED_IN != 0) && a_reg[INT_W-1];

  // Leading-zero count of the magnitude; the highest set bit wins because it
  // is visited last. An all-zero magnitude gives INT_W.
  always_comb begin
    lzc = LZ_W'(INT_W);
    for (int i = 0; i < INT_W; i++) begin
      if (mag[i]) lzc = LZ_W'(INT_W - 1 - i);
    end
  end

  // Padding 26 zero bits below the normalised value lets the mantissa, guard
  // and round bits be sliced uniformly even when INT_W is narrower than 24.
  assign norm = mag << lzc;
  assign wide = {norm, 26'd0};

  assign mant_inc = {1'b0, mant} + 25'd1;

`ifdef INT2FLOAT_RMODE_EN
  always_comb begin
    round_up = 1'b0;
    case (rmode_reg)
      2'b00:   round_up = g & (r | s | mant[0]);
      2'b01:   round_up = 1'b0;
      2'b10:   round_up = (g | r | s) & ~sign;
      default: round_up = (g | r | s) & sign;
    endcase
  end
`else
  assign round_up = g & (r | s | mant[0]);
`endif

  // Conversion FSM. Outputs are registered; the result strobe rises one
  // cycle after PUT_Z is entered so the packed word is already stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= GET_A;
      bus.input_a_ack  <= 1'b0;
      bus.output_z_stb <= 1'b0;
      bus.output_z     <= 32'd0;
      bus.output_z_inx <= 1'b0;
      a_reg            <= '0;
      mag              <= '0;
      sign             <= 1'b0;
      mant             <= 24'd0;
      g                <= 1'b0;
      r                <= 1'b0;
      s                <= 1'b0;
      exp_q            <= 8'd0;
      zero             <= 1'b1;
      inx              <= 1'b0;
`ifdef INT2FLOAT_RMODE_EN
      rmode_reg        <= 2'b00;
`endif
    end else begin
      case (state)
        GET_A: begin
          if (bus.input_a_ack && bus.input_a_stb) begin
            a_reg           <= bus.input_a;
`ifdef INT2FLOAT_RMODE_EN
            rmode_reg       <= bus.input_rmode;
`endif
            bus.input_a_ack <= 1'b0;
            state           <= ABS;
          end else begin
            bus.input_a_ack <= 1'b1;
          end
        end
        ABS: begin
          sign  <= neg;
          mag   <= neg ? -a_reg : a_reg;
          state <= NORM;
        end
        NORM: begin
          mant  <= wide[INT_W+25 -: 24];
          g     <= wide[INT_W+1];
          r     <= wide[INT_W];
          s     <= |wide[INT_W-1:0];
          exp_q <= 8'(INT_W - 1) - 8'(lzc);
          zero  <= (mag == '0);
          state <= ROUND;
        end
        ROUND: begin
          inx <= g | r | s;
          if (round_up) begin
            if (mant_inc[24]) begin
              mant  <= 24'h800000;
              exp_q <= exp_q + 8'd1;
            end else begin
              mant <= mant_inc[23:0];
            end
          end
          state <= PACK;
        end
        PACK: begin
          if (zero) begin
            bus.output_z     <= 32'd0;
            bus.output_z_inx <= 1'b0;
          end else begin
            bus.output_z     <= {sign, exp_q + 8'd127, mant[22:0]};
            bus.output_z_inx <= inx;
          end
          state <= PUT_Z;
        end
        PUT_Z: begin
          if (!bus.output_z_stb) begin
            bus.output_z_stb <= 1'b1;
          end else if (bus.output_z_ack) begin
            bus.output_z_stb <= 1'b0;
            state            <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_int2float_param.sv
// ---------------------------------------------------------------------------
// tb_int2float_param
// Self-checking bench for int2float_param (INT_W=32). A signed and an
// unsigned instance run in lockstep from the same stimulus; every vector
// carries the expected result for both.
// Configuration macro: INT2FLOAT_RMODE_EN (adds directed rounding-mode vectors)
// ---------------------------------------------------------------------------
module tb_int2float_param;

  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  rmode;
    logic [31:0] z;
    logic        inx;
    logic [31:0] uz;
    logic        uinx;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs[$];

  int2float_param_if #(.INT_W(32)) bus ();
  int2float_param_if #(.INT_W(32)) u_bus ();

  int2float_param #(.INT_W(32), .SIGNED_IN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int2float_param #(.INT_W(32), .SIGNED_IN(0)) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (u_bus.slave)
  );

  // The unsigned instance sees exactly the same operand stream and result ack.
  assign u_bus.input_a      = bus.input_a;
  assign u_bus.input_a_stb  = bus.input_a_stb;
  assign u_bus.output_z_ack = bus.output_z_ack;
`ifdef INT2FLOAT_RMODE_EN
  assign u_bus.input_rmode  = bus.input_rmode;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for input_a_ack, transfers one operand, then counts edges
  // until output_z_stb. Called and returns at posedge+1.
  task automatic applyStimulus(input logic [31:0] a, input logic [1:0] rmode, output int lat);
    int n;
    n = 0;
    while (bus.input_a_ack !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) $display("[TB] FAIL ack_wait: input_a_ack never rose for a=%h rm=%0d", a, rmode);
    checkOutput("ack_wait", 32'(n < 50), 32'd1);
    bus.input_a     = a;
`ifdef INT2FLOAT_RMODE_EN
    bus.input_rmode = rmode;
`endif
    bus.input_a_stb = 1'b1;
    @(posedge clk); #1;
    bus.input_a_stb = 1'b0;
    lat = 0;
    while (bus.output_z_stb !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runVector(input int idx, input vec_t v);
    int lat;
    applyStimulus(v.a, v.rmode, lat);
    checkOutput($sformatf("latency[%0d]", idx), 32'(lat), 32'd5);
    checkOutput($sformatf("z[%0d]", idx), bus.output_z, v.z);
    checkOutput($sformatf("inx[%0d]", idx), 32'(bus.output_z_inx), 32'(v.inx));
    checkOutput($sformatf("uz[%0d]", idx), u_bus.output_z, v.uz);
    checkOutput($sformatf("uinx[%0d]", idx), 32'(u_bus.output_z_inx), 32'(v.uinx));
    bus.output_z_ack = 1'b1;
    @(posedge clk); #1;
    bus.output_z_ack = 1'b0;
    checkOutput($sformatf("stb_drop[%0d]", idx), 32'(bus.output_z_stb), 32'd0);
  endtask

  initial begin
    int lat;
    int errs;
    total = 0;
    bad   = 0;

    //              a             rm     z             inx   uz            uinx
    vecs.push_back({32'h00000000, 2'b00, 32'h00000000, 1'b0, 32'h00000000, 1'b0});
    vecs.push_back({32'h00000001, 2'b00, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0});
    vecs.push_back({32'hFFFFFFFF, 2'b00, 32'hBF800000, 1'b0, 32'h4F800000, 1'b1});
    vecs.push_back({32'h80000000, 2'b00, 32'hCF000000, 1'b0, 32'h4F000000, 1'b0});
    vecs.push_back({32'h01000001, 2'b00, 32'h4B800000, 1'b1, 32'h4B800000, 1'b1});
    vecs.push_back({32'h01000003, 2'b00, 32'h4B800002, 1'b1, 32'h4B800002, 1'b1});
    vecs.push_back({32'h7FFFFFFF, 2'b00, 32'h4F000000, 1'b1, 32'h4F000000, 1'b1});
    vecs.push_back({32'h01000000, 2'b00, 32'h4B800000, 1'b0, 32'h4B800000, 1'b0});
    vecs.push_back({32'hFEFFFFFF, 2'b00, 32'hCB800000, 1'b1, 32'h4F7F0000, 1'b1});
    vecs.push_back({32'h00FFFFFF, 2'b00, 32'h4B7FFFFF, 1'b0, 32'h4B7FFFFF, 1'b0});
    vecs.push_back({32'h00000064, 2'b00, 32'h42C80000, 1'b0, 32'h42C80000, 1'b0});
    vecs.push_back({32'hFFFFFF9C, 2'b00, 32'hC2C80000, 1'b0, 32'h4F800000, 1'b1});
    vecs.push_back({32'h02000003, 2'b00, 32'h4C000001, 1'b1, 32'h4C000001, 1'b1});
`ifdef INT2FLOAT_RMODE_EN
    vecs.push_back({32'h7FFFFFFF, 2'b01, 32'h4EFFFFFF, 1'b1, 32'h4EFFFFFF, 1'b1});
    vecs.push_back({32'hFEFFFFFF, 2'b11, 32'hCB800001, 1'b1, 32'h4F7EFFFF, 1'b1});
    vecs.push_back({32'hFEFFFFFF, 2'b10, 32'hCB800000, 1'b1, 32'h4F7F0000, 1'b1});
    vecs.push_back({32'h01000001, 2'b10, 32'h4B800001, 1'b1, 32'h4B800001, 1'b1});
    vecs.push_back({32'h01000001, 2'b11, 32'h4B800000, 1'b1, 32'h4B800000, 1'b1});
    vecs.push_back({32'hFFFFFFFF, 2'b01, 32'hBF800000, 1'b0, 32'h4F7FFFFF, 1'b1});
    vecs.push_back({32'h00000000, 2'b11, 32'h00000000, 1'b0, 32'h00000000, 1'b0});
`endif

    // Reset state
    rst              = 1'b1;
    bus.input_a      = 32'd0;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b0;
`ifdef INT2FLOAT_RMODE_EN
    bus.input_rmode  = 2'b00;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ack", 32'(bus.input_a_ack), 32'd0);
    checkOutput("rst_stb", 32'(bus.output_z_stb), 32'd0);
    checkOutput("rst_z", bus.output_z, 32'd0);
    checkOutput("rst_inx", 32'(bus.output_z_inx), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("ack_after_rst", 32'(bus.input_a_ack), 32'd1);

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) runVector(i, vecs[i]);

    // Backpressure: result held for 10 cycles with ack low
    applyStimulus(32'd2, 2'b00, lat);
    checkOutput("bp_latency", 32'(lat), 32'd5);
    errs = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.output_z_stb !== 1'b1 || bus.output_z !== 32'h40000000 || bus.input_a_ack !== 1'b0)
        errs++;
      @(posedge clk); #1;
    end
    checkOutput("bp_hold_errors", 32'(errs), 32'd0);
    checkOutput("bp_z", bus.output_z, 32'h40000000);
    bus.output_z_ack = 1'b1;
    @(posedge clk); #1;
    bus.output_z_ack = 1'b0;
    checkOutput("bp_stb_drop", 32'(bus.output_z_stb), 32'd0);
    checkOutput("bp_ack_still_low", 32'(bus.input_a_ack), 32'd0);
    @(posedge clk); #1;
    checkOutput("bp_ack_rise", 32'(bus.input_a_ack), 32'd1);

    // Back-to-back: stb and result ack held high, one result per operand
    bus.input_a      = 32'd3;
    bus.input_a_stb  = 1'b1;
    bus.output_z_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      while (bus.input_a_ack !== 1'b1 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput("b2b_ack_wait", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      checkOutput("b2b_ack_drop", 32'(bus.input_a_ack), 32'd0);
      lat = 0;
      while (bus.output_z_stb !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      checkOutput("b2b_latency", 32'(lat), 32'd5);
      checkOutput("b2b_z", bus.output_z, 32'h40400000);
      @(posedge clk); #1;
      checkOutput("b2b_stb_single", 32'(bus.output_z_stb), 32'd0);
    end
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b0;

    // Reset while in NORM: operand dropped, then a fresh conversion works
    lat = 0;
    while (bus.input_a_ack !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.input_a     = 32'd9;
    bus.input_a_stb = 1'b1;
    @(posedge clk); #1;
    bus.input_a_stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstn_ack", 32'(bus.input_a_ack), 32'd0);
    checkOutput("rstn_stb", 32'(bus.output_z_stb), 32'd0);
    checkOutput("rstn_z", bus.output_z, 32'd0);
    @(posedge clk); #1;
    checkOutput("rstn_ack_rise", 32'(bus.input_a_ack), 32'd1);
    runVector(100, {32'h00000002, 2'b00, 32'h40000000, 1'b0, 32'h40000000, 1'b0});

    // Reset while in PUT_Z
    applyStimulus(32'd7, 2'b00, lat);
    checkOutput("rstp_pre_z", bus.output_z, 32'h40E00000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstp_ack", 32'(bus.input_a_ack), 32'd0);
    checkOutput("rstp_stb", 32'(bus.output_z_stb), 32'd0);
    checkOutput("rstp_z", bus.output_z, 32'd0);
    @(posedge clk); #1;
    checkOutput("rstp_ack_rise", 32'(bus.input_a_ack), 32'd1);
    runVector(101, {32'h00000002, 2'b00, 32'h40000000, 1'b0, 32'h40000000, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
